// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: instruction handshake in, register writeback in,
// decoded ALU operation handshake out.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready are both 1. The producer holds valid and its payload
// stable until that edge; ready may depend combinationally on the consumer's
// state but never on the producer's valid.
interface operand_fetch_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ALUOp;
  logic [31:0] MuxOutA;
  logic [31:0] MuxOutB;
  logic [4:0]  ex_rd;
  logic        illegal;

  // Front end / writeback / ALU side
  modport master (
    output instr, instr_valid, wb_en, wb_addr, wb_data, ex_ready,
    input  instr_ready, ex_valid, ALUOp, MuxOutA, MuxOutB, ex_rd, illegal
  );

  // Operand-fetch stage
  modport slave (
    input  instr, instr_valid, wb_en, wb_addr, wb_data, ex_ready,
    output instr_ready, ex_valid, ALUOp, MuxOutA, MuxOutB, ex_rd, illegal
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch / decode stage for a small MIPS subset. Reads two source
// registers (with same-cycle writeback bypass), decodes the ALU operation
// and holds it in a single output register until the ALU stage consumes it.
module operand_fetch (
  input  logic clk,
  input  logic rst_n,
  operand_fetch_if.slave bus
);

  logic [31:0] regs [32];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic        dec_legal;
  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;

  logic        accept;
  logic        ex_valid_q;
  logic        illegal_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;

  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];
  assign rs_idx = bus.instr[25:21];
  assign rt_idx = bus.instr[20:16];

  // A new instruction may enter whenever the output slot is empty or draining.
  assign bus.instr_ready = !ex_valid_q || bus.ex_ready;
  assign accept          = bus.instr_valid && bus.instr_ready;

  assign bus.ex_valid = ex_valid_q;
  assign bus.illegal  = illegal_q;
  assign bus.ALUOp    = op_q;
  assign bus.MuxOutA  = a_q;
  assign bus.MuxOutB  = b_q;
  assign bus.ex_rd    = rd_q;

  // Register file write port; r0 is never written so it always reads 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Read ports: r0 forced to 0, a same-cycle writeback to the index wins.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_idx != 5'd0)
      rs_val = (bus.wb_en && bus.wb_addr == rs_idx) ? bus.wb_data : regs[rs_idx];
    if (rt_idx != 5'd0)
      rt_val = (bus.wb_en && bus.wb_addr == rt_idx) ? bus.wb_data : regs[rt_idx];
  end

  // Decode the presented instruction into ALU op, operands and destination.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 4'b0000;
    dec_a     = rs_val;
    dec_b     = rt_val;
    dec_rd    = bus.instr[15:11];
    case (opcode)
      6'h00: begin
        dec_legal = 1'b1;
        case (funct)
          6'h20: dec_op = 4'b0000;
          6'h22: dec_op = 4'b0010;
          6'h24: dec_op = 4'b0011;
          6'h25: dec_op = 4'b0101;
          6'h2A: dec_op = 4'b1001;
          6'h00: begin dec_op = 4'b0110; dec_a = {27'b0, bus.instr[10:6]}; end
          6'h02: begin dec_op = 4'b0111; dec_a = {27'b0, bus.instr[10:6]}; end
          6'h03: begin dec_op = 4'b1000; dec_a = {27'b0, bus.instr[10:6]}; end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin
        dec_legal = 1'b1;
        dec_op    = 4'b0001;
        dec_b     = {{16{bus.instr[15]}}, bus.instr[15:0]};
        dec_rd    = rt_idx;
      end
      6'h0C: begin
        dec_legal = 1'b1;
        dec_op    = 4'b0100;
        dec_b     = {16'h0000, bus.instr[15:0]};
        dec_rd    = rt_idx;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Output register: load on legal acceptance, drain on consume, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
    end else begin
      illegal_q <= accept && !dec_legal;
      if (accept && dec_legal) begin
        ex_valid_q <= 1'b1;
        op_q       <= dec_op;
        a_q        <= dec_a;
        b_q        <= dec_b;
        rd_q       <= dec_rd;
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written stall /
// bypass / reset sequences, then randomized traffic against a reference model.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if bus();

  operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic        m_ill;
  logic [3:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [4:0]  m_rd;
  logic [72:0] exp_q [$];

  typedef struct {
    logic [5:0] funct;
    logic [3:0] op;
    bit         shift;
  } rop_t;
  rop_t rops [8];

  typedef struct {
    logic [31:0] instr;
    bit          exp_valid;
    bit          exp_ill;
    logic [3:0]  exp_op;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [4:0]  exp_rd;
  } vec_t;
  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int funct);
    logic [31:0] w;
    w = {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], funct[5:0]};
    return w;
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
    return m_regs[idx];
  endfunction

  task automatic ref_decode(input logic [31:0] w, input logic [31:0] rs_v, input logic [31:0] rt_v,
                            output bit legal, output logic [3:0] op, output logic [31:0] a,
                            output logic [31:0] b, output logic [4:0] rd);
    legal = 1'b0; op = 4'd0; a = rs_v; b = rt_v; rd = w[15:11];
    if (w[31:26] == 6'h00) begin
      for (int i = 0; i < 8; i++) begin
        if (rops[i].funct == w[5:0]) begin
          legal = 1'b1;
          op = rops[i].op;
          if (rops[i].shift) a = 32'(w[10:6]);
        end
      end
    end else if (w[31:26] == 6'h08) begin
      legal = 1'b1; op = 4'd1; rd = w[20:16];
      b = 32'($signed(w[15:0]));
    end else if (w[31:26] == 6'h0C) begin
      legal = 1'b1; op = 4'd4; rd = w[20:16];
      b = 32'(w[15:0]);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    bit          acc;
    bit          legal;
    logic [31:0] rs_v, rt_v, a, b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [72:0] want, got;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_valid = 1'b0; m_ill = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_rd = '0;
      exp_q.delete();
    end else begin
      acc = bus.instr_valid && (!m_valid || bus.ex_ready);
      if (m_valid && bus.ex_ready) begin
        checks++;
        got = {bus.ALUOp, bus.MuxOutA, bus.MuxOutB, bus.ex_rd};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow actual=%h expected=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL scoreboard_consume actual=%h expected=%h at %0t", got, want, $time);
          end
        end
      end
      rs_v = ref_read(bus.instr[25:21]);
      rt_v = ref_read(bus.instr[20:16]);
      ref_decode(bus.instr, rs_v, rt_v, legal, op, a, b, rd);
      if (bus.wb_en && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
      m_ill = acc && !legal;
      if (acc && legal) begin
        m_valid = 1'b1; m_op = op; m_a = a; m_b = b; m_rd = rd;
        exp_q.push_back({op, a, b, rd});
      end else if (bus.ex_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // One clock: check ready before the edge, outputs one step after it.
  task automatic tick();
    #1;
    chk("instr_ready", 32'(bus.instr_ready), 32'(!m_valid || bus.ex_ready));
    model_step();
    @(posedge clk);
    #1;
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk("illegal", 32'(bus.illegal), 32'(m_ill));
    chk("ALUOp", 32'(bus.ALUOp), 32'(m_op));
    chk("MuxOutA", bus.MuxOutA, m_a);
    chk("MuxOutB", bus.MuxOutB, m_b);
    chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
    bus.instr_valid = 1'b0;
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic chk_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    chk({tag, "_valid"}, 32'(bus.ex_valid), 32'd1);
    chk({tag, "_op"}, 32'(bus.ALUOp), 32'(op));
    chk({tag, "_a"}, bus.MuxOutA, a);
    chk({tag, "_b"}, bus.MuxOutB, b);
    chk({tag, "_rd"}, 32'(bus.ex_rd), 32'(rd));
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rs, rt, rd, sh;
    k  = $urandom_range(0, 11);
    rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
    rd = $urandom_range(0, 7); sh = $urandom_range(0, 31);
    if (k < 8)   return rtype(rs, rt, rd, sh, int'(rops[k].funct));
    if (k == 8)  return itype(8'h08, rs, rt, int'($urandom_range(0, 65535)));
    if (k == 9)  return itype(8'h0C, rs, rt, int'($urandom_range(0, 65535)));
    if (k == 10) return rtype(rs, rt, rd, sh, int'($urandom_range(0, 63)));
    return $urandom();
  endfunction

  initial begin
    rops[0] = '{6'h20, 4'b0000, 1'b0};
    rops[1] = '{6'h22, 4'b0010, 1'b0};
    rops[2] = '{6'h24, 4'b0011, 1'b0};
    rops[3] = '{6'h25, 4'b0101, 1'b0};
    rops[4] = '{6'h2A, 4'b1001, 1'b0};
    rops[5] = '{6'h00, 4'b0110, 1'b1};
    rops[6] = '{6'h02, 4'b0111, 1'b1};
    rops[7] = '{6'h03, 4'b1000, 1'b1};

    // Directed vectors, assuming r1=5 and r2=7
    vec[0]  = '{rtype(1, 2, 3, 0, 'h20),  1, 0, 4'b0000, 32'd5,  32'd7, 5'd3};
    vec[1]  = '{rtype(1, 2, 3, 0, 'h22),  1, 0, 4'b0010, 32'd5,  32'd7, 5'd3};
    vec[2]  = '{rtype(2, 1, 8, 0, 'h24),  1, 0, 4'b0011, 32'd7,  32'd5, 5'd8};
    vec[3]  = '{rtype(1, 2, 9, 0, 'h25),  1, 0, 4'b0101, 32'd5,  32'd7, 5'd9};
    vec[4]  = '{rtype(1, 2, 10, 0, 'h2A), 1, 0, 4'b1001, 32'd5,  32'd7, 5'd10};
    vec[5]  = '{rtype(0, 2, 11, 4, 'h00), 1, 0, 4'b0110, 32'd4,  32'd7, 5'd11};
    vec[6]  = '{rtype(0, 2, 12, 31, 'h02), 1, 0, 4'b0111, 32'd31, 32'd7, 5'd12};
    vec[7]  = '{rtype(2, 2, 5, 3, 'h03),  1, 0, 4'b1000, 32'd3,  32'd7, 5'd5};
    vec[8]  = '{itype('h08, 1, 4, 'hFFFF), 1, 0, 4'b0001, 32'd5, 32'hFFFF_FFFF, 5'd4};
    vec[9]  = '{itype('h0C, 1, 4, 'hFFFF), 1, 0, 4'b0100, 32'd5, 32'h0000_FFFF, 5'd4};
    vec[10] = '{itype('h08, 2, 13, 'h7FFF), 1, 0, 4'b0001, 32'd7, 32'h0000_7FFF, 5'd13};
    vec[11] = '{itype('h23, 1, 2, 4),      0, 1, 4'b0000, 32'd0, 32'd0, 5'd0};
    vec[12] = '{rtype(1, 2, 3, 0, 'h21),  0, 1, 4'b0000, 32'd0, 32'd0, 5'd0};

    // Reset
    bus.instr = '0; bus.instr_valid = 1'b0; bus.ex_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    rst_n = 1'b0;
    model_step();
    @(posedge clk);
    #1;
    tick();
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_ALUOp", 32'(bus.ALUOp), 32'd0);
    chk("rst_MuxOutA", bus.MuxOutA, 32'd0);
    chk("rst_MuxOutB", bus.MuxOutB, 32'd0);
    chk("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
    rst_n = 1'b1;
    bus.ex_ready = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.instr_ready), 32'd1);
    bus.ex_ready = 1'b1;

    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd7);

    // Table-driven single-instruction decode
    for (int i = 0; i < 13; i++) begin
      bus.instr = vec[i].instr; bus.instr_valid = 1'b1; bus.ex_ready = 1'b1;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(bus.ex_valid), 32'(vec[i].exp_valid));
      chk($sformatf("tbl%0d_illegal", i), 32'(bus.illegal), 32'(vec[i].exp_ill));
      if (vec[i].exp_valid) begin
        chk($sformatf("tbl%0d_op", i), 32'(bus.ALUOp), 32'(vec[i].exp_op));
        chk($sformatf("tbl%0d_a", i), bus.MuxOutA, vec[i].exp_a);
        chk($sformatf("tbl%0d_b", i), bus.MuxOutB, vec[i].exp_b);
        chk($sformatf("tbl%0d_rd", i), 32'(bus.ex_rd), 32'(vec[i].exp_rd));
      end
      bus.instr_valid = 1'b0;
      tick();
      chk($sformatf("tbl%0d_ill_pulse_end", i), 32'(bus.illegal), 32'd0);
    end

    // Stall with a pending instruction while r1 is rewritten
    bus.instr = rtype(1, 2, 3, 0, 'h20); bus.instr_valid = 1'b1; bus.ex_ready = 1'b1;
    tick();
    chk_op("stall_first", 4'b0000, 32'd5, 32'd7, 5'd3);
    bus.instr = rtype(1, 2, 6, 0, 'h22); bus.ex_ready = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_op($sformatf("stall_hold%0d", k), 4'b0000, 32'd5, 32'd7, 5'd3);
      chk($sformatf("stall_ready%0d", k), 32'(bus.instr_ready), 32'd0);
    end
    bus.wb_en = 1'b0; bus.ex_ready = 1'b1;
    tick();
    chk_op("stall_release", 4'b0010, 32'd9, 32'd7, 5'd6);
    bus.instr_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(bus.ex_valid), 32'd0);

    // Writeback bypass on acceptance, then r0 write ignored
    bus.wb_en = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'hAAAA_0000;
    bus.instr = rtype(2, 0, 6, 0, 'h25); bus.instr_valid = 1'b1;
    tick();
    chk_op("bypass_or", 4'b0101, 32'hAAAA_0000, 32'd0, 5'd6);
    bus.instr_valid = 1'b0;
    write_reg(5'd0, 32'h1234_5678);
    bus.instr = rtype(0, 2, 7, 0, 'h20); bus.instr_valid = 1'b1;
    tick();
    chk_op("r0_zero", 4'b0000, 32'd0, 32'hAAAA_0000, 5'd7);
    bus.instr_valid = 1'b0;
    tick();

    // Reset in the middle of a stall; writes during reset are dropped
    bus.instr = rtype(1, 2, 3, 0, 'h20); bus.instr_valid = 1'b1; bus.ex_ready = 1'b1;
    tick();
    bus.instr = rtype(1, 2, 6, 0, 'h22); bus.ex_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h55;
    tick();
    chk("midrst_valid", 32'(bus.ex_valid), 32'd0);
    chk("midrst_illegal", 32'(bus.illegal), 32'd0);
    chk("midrst_op", 32'(bus.ALUOp), 32'd0);
    chk("midrst_a", bus.MuxOutA, 32'd0);
    chk("midrst_b", bus.MuxOutB, 32'd0);
    chk("midrst_rd", 32'(bus.ex_rd), 32'd0);
    rst_n = 1'b1; bus.wb_en = 1'b0; bus.instr_valid = 1'b0; bus.ex_ready = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.instr_ready), 32'd1);
    bus.instr = rtype(1, 5, 3, 0, 'h20); bus.instr_valid = 1'b1; bus.ex_ready = 1'b1;
    tick();
    chk_op("regs_cleared", 4'b0000, 32'd0, 32'd0, 5'd3);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst_n           = ($urandom_range(0, 99) != 0);
      bus.instr       = rand_instr();
      bus.instr_valid = $urandom_range(0, 3) != 0;
      bus.ex_ready    = $urandom_range(0, 2) != 0;
      bus.wb_en       = $urandom_range(0, 1) != 0;
      bus.wb_addr     = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 The block SHALL provide these ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr  in  32  MIPS instruction word
- instr_valid  in  1  instr is presented
- instr_ready  out  1  block accepts instr this cycle
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write register index
- wb_data  in  32  write data
- ex_valid  out  1  ALUOp/MuxOutA/MuxOutB/ex_rd hold a valid operation
- ex_ready  in  1  downstream ALU stage consumes this cycle
- ALUOp  out  4  ALU operation code
- MuxOutA  out  32  ALU operand A (shift amount for shifts)
- MuxOutB  out  32  ALU operand B
- ex_rd  out  5  destination register of the issued operation
- illegal  out  1  one-cycle pulse when an undecodable instruction is consumed

Function
REQ-003 The register file SHALL be 32 x 32 bits, with two combinational read ports (rs = instr[25:21], rt = instr[20:16]) and one write port.
REQ-004 Register 0 SHALL always read 0, and writes with wb_addr = 0 SHALL be ignored.
REQ-005 When wb_en=1 and wb_addr equals a nonzero read index in the same cycle, the read SHALL return wb_data (write-before-read bypass).
REQ-006 The block SHALL assert instr_ready = !ex_valid || ex_ready, combinationally.
REQ-007 An instruction SHALL be accepted on an edge where instr_valid && instr_ready; the decoded result SHALL appear on the outputs the following cycle (1-cycle latency).
REQ-008 While ex_valid && !ex_ready, ex_valid, ALUOp, MuxOutA, MuxOutB and ex_rd SHALL hold stable.
REQ-009 Operands SHALL be sampled at acceptance; a later writeback to a source register SHALL NOT alter a stalled output.
REQ-010 On an edge with ex_ready=1 and no acceptance, ex_valid SHALL go to 0.
REQ-011 Simultaneous consume and accept SHALL replace the output register with no bubble.
REQ-012 For R-type instructions (opcode 0x00), decoding by funct SHALL be:
- 0x20 ADD -> 0000
- 0x22 SUB -> 0010
- 0x24 AND -> 0011
- 0x25 OR -> 0101
- 0x2A SLT -> 1001
- 0x00 SLL -> 0110
- 0x02 SRL -> 0111
- 0x03 SRA -> 1000
REQ-013 For R-type instructions, ex_rd SHALL be instr[15:11] and MuxOutB SHALL be the rt value.
REQ-014 For R-type instructions, MuxOutA SHALL be the rs value, except for shifts, where MuxOutA = {27'b0, instr[10:6]}.
REQ-015 ADDI (opcode 0x08) SHALL issue ALUOp 0001 with MuxOutA = rs value, MuxOutB = sign-extended instr[15:0] and ex_rd = rt index.
REQ-016 ANDI (opcode 0x0C) SHALL issue ALUOp 0100 with MuxOutA = rs value, MuxOutB = zero-extended instr[15:0] and ex_rd = rt index.
REQ-017 Any other opcode/funct SHALL be consumed when accepted, SHALL NOT set ex_valid, and SHALL pulse illegal for exactly the next cycle.
REQ-018 In the illegal case of REQ-017, an already valid but unconsumed output SHALL be unaffected; this cannot occur, because acceptance requires instr_ready.

Reset
REQ-019 While rst_n=0 at an edge, the block SHALL clear ex_valid, illegal, ALUOp, MuxOutA, MuxOutB, ex_rd and all 32 registers to 0.
REQ-020 Reset SHALL discard any held operation, and writes are ignored during reset.
REQ-021 instr_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-022 The bench SHALL write r1=5, r2=7 and then issue ADD r3,r1,r2 -> next cycle ex_valid=1, ALUOp=0000, MuxOutA=5, MuxOutB=7, ex_rd=3.
REQ-023 The bench SHALL issue ADDI r4,r1,-1 (imm 0xFFFF) -> MuxOutB=0xFFFFFFFF, ALUOp=0001, ex_rd=4; ANDI with the same imm -> MuxOutB=0x0000FFFF, ALUOp=0100.
REQ-024 The bench SHALL issue SRA r5,r2,shamt=3 -> ALUOp=1000, MuxOutA=3, MuxOutB=7.
REQ-025 The bench SHALL hold ex_ready=0 for 3 cycles with a second instruction pending, and write r1=9 meanwhile -> outputs unchanged, instr_ready=0; on ex_ready=1 the next operation issues with no bubble.
REQ-026 The bench SHALL write r2=0xAAAA0000 in the same cycle as accepting OR r6,r2,r0 -> MuxOutA=0xAAAA0000, MuxOutB=0; a write to r0 -> r0 still reads 0.
REQ-027 The bench SHALL issue opcode 0x23 -> illegal pulses for 1 cycle with ex_valid=0; applying rst_n=0 mid-stall -> ex_valid=0 and all outputs 0 next cycle.
